axi4_burst_master: RTL
======================

Name: axi4_burst_master

Overview:
Synthesizable AXI4 full master that turns single commands into one AXI4 burst (FIXED/INCR/WRAP, 1-256 beats). Write data is taken from a valid/ready stream; read data is returned on a valid/ready stream. Each command ends with a one-cycle completion status. Used as the on-chip traffic source in front of AXI4 slaves such as axi4dummy, and as the bus driver in self-checking benches.

Parameters:
AWIDTH, 64, address width
DWIDTH, 64, data width; power of 2, 8..1024
IDWIDTH, 4, AXI ID width
DBYTES, DWIDTH/8, derived; strobe width

Ports:
clock_axi  in  1  single clock; all logic on rising edge
reset_axi_n  in  1  synchronous active-low reset
cmd_valid / cmd_ready  in/out  1/1  command handshake
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr / cmd_id  in  AWIDTH/IDWIDTH  start address, transaction ID
cmd_len / cmd_size / cmd_burst  in  8/3/2  AxLEN, AxSIZE, AxBURST
wr_data / wr_strb  in  DWIDTH/DBYTES  write beat payload
wr_valid / wr_ready  in/out  1/1  write stream handshake
rd_data / rd_last  out  DWIDTH/1  read beat payload, last beat
rd_valid / rd_ready  out/in  1/1  read stream handshake
done / done_write / done_resp  out  1/1/2  completion pulse, direction, response
m_axi_aw{addr,id,len,size,burst}  out  AWIDTH,IDWIDTH,8,3,2  AW payload
m_axi_awvalid / m_axi_awready  out/in  1/1
m_axi_w{data,strb,last}  out  DWIDTH,DBYTES,1  W payload
m_axi_wvalid / m_axi_wready  out/in  1/1
m_axi_b{id,resp}  in  IDWIDTH,2;  m_axi_bvalid in 1;  m_axi_bready out 1
m_axi_ar{addr,id,len,size,burst}  out  as AW;  m_axi_arvalid out 1;  m_axi_arready in 1
m_axi_r{id,data,resp,last}  in  IDWIDTH,DWIDTH,2,1;  m_axi_rvalid in 1;  m_axi_rready out 1

Behaviour:
- States: IDLE, WRITE (AW+W), WAIT_B, RADDR, RDATA, DONE.
- Reset (reset_axi_n=0 at an edge): state IDLE. All valids, wlast, bready, rready, done and done_resp are 0. cmd_ready=0 while in reset and 1 the cycle after.
- Reset mid-burst aborts at once: valids drop at that edge, no done pulse.
- IDLE: cmd_ready=1. Accepting a command (cmd_valid&cmd_ready) registers all cmd fields and sets cmd_ready=0.
- cmd_size > log2(DBYTES): no bus traffic. Go to DONE with done_resp=2'b10.
- Otherwise, next cycle: awvalid=1 (write, state WRITE) or arvalid=1 (read, state RADDR). Payload comes from the registered fields and stays stable until the handshake.
- WRITE: AW and W progress independently; W beats may finish before the AW handshake.
  - m_axi_wvalid = wr_valid & beats remaining.
  - wr_ready = m_axi_wready & beats remaining; wdata/wstrb are combinational pass-through.
  - An 8-bit beat counter counts W handshakes. wlast=1 when counter==len.
  - When AW is handshaken and the last W beat is done: go to WAIT_B with bready=1.
- WAIT_B: on bvalid, done_resp=bresp. If bid != registered ID, done_resp=2'b10 instead. Go to DONE.
- RADDR: hold arvalid until arready, then go to RDATA.
- RDATA: rready = rd_ready; rd_valid = rvalid; rd_data = rdata; rd_last = rlast.
  - Status accumulates the maximum rresp over all beats.
  - A rid mismatch, or rlast on a beat other than beat len, forces 2'b10.
  - Missing rlast: beats past len are still consumed until rlast, with error.
  - rlast handshake: go to DONE.
- DONE: done=1 for exactly one cycle; done_write reflects the command direction. Return to IDLE, with cmd_ready=1 the following cycle.
- Latency: minimum cmd accept to done for a 1-beat write with a zero-wait slave is 4 cycles.
- Only one command is outstanding at a time. IDs are echoed, never reordered.

Optional Feature:
AXI4_BURST_CHECK_EN
- Defined: commands are checked at acceptance and rejected before any bus traffic (DONE with done_resp=2'b10) if:
  - an INCR burst crosses a 4 KB boundary,
  - a WRAP burst has len not in {1,3,7,15} or an address not aligned to size,
  - cmd_burst==2'b11.
- Undefined: no check; commands are issued as given, apart from the cmd_size rule.

Test Plan:
- Write, len=0, size=3, INCR, addr 0x0, wr_data 0xDEADBEEFDEADBEEF, zero-wait slave -> one W beat with wlast=1; done after 4 cycles, done_resp=00. Read back -> rd_data 0xDEADBEEFDEADBEEF, rd_last=1.
- INCR write, len=7, addr 0x100, data 0..7; wr_valid gapped every 2nd cycle and wready stalled 3 cycles -> exactly 8 W beats, wlast only on beat 8. Read back 0..7 in order.
- Slave asserts wready before awready (AW delayed 5 cycles) -> all W beats complete first; single done, resp 00.
- Read slave returns rlast on beat 3 of len=7, and a second run returns bid=5 for cmd_id=2 -> done_resp=2'b10 in both cases.
- rd_ready held low 10 cycles mid-burst -> rready low, no beat lost; stream data matches memory.
- Macro defined: INCR addr 0xFF8, len=1 -> no awvalid, done with 2'b10. Macro undefined: same command is issued on the bus. Separately, reset asserted mid-burst -> all valids 0 the next cycle and no done pulse.

Source files
------------

// File: rtl/axi4_burst_master.sv
// AXI4 burst master: one command in, one FIXED/INCR/WRAP burst out, one-cycle completion status.
// Optional acceptance-time burst legality check enabled by defining AXI4_BURST_CHECK_EN.
module axi4_burst_master #(
    parameter int AWIDTH  = 64,
    parameter int DWIDTH  = 64,
    parameter int IDWIDTH = 4,
    parameter int DBYTES  = DWIDTH / 8
) (
    input  logic               clock_axi,
    input  logic               reset_axi_n,

    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [AWIDTH-1:0]  cmd_addr,
    input  logic [IDWIDTH-1:0] cmd_id,
    input  logic [7:0]         cmd_len,
    input  logic [2:0]         cmd_size,
    input  logic [1:0]         cmd_burst,

    input  logic [DWIDTH-1:0]  wr_data,
    input  logic [DBYTES-1:0]  wr_strb,
    input  logic               wr_valid,
    output logic               wr_ready,

    output logic [DWIDTH-1:0]  rd_data,
    output logic               rd_last,
    output logic               rd_valid,
    input  logic               rd_ready,

    output logic               done,
    output logic               done_write,
    output logic [1:0]         done_resp,

    output logic [AWIDTH-1:0]  m_axi_awaddr,
    output logic [IDWIDTH-1:0] m_axi_awid,
    output logic [7:0]         m_axi_awlen,
    output logic [2:0]         m_axi_awsize,
    output logic [1:0]         m_axi_awburst,
    output logic               m_axi_awvalid,
    input  logic               m_axi_awready,

    output logic [DWIDTH-1:0]  m_axi_wdata,
    output logic [DBYTES-1:0]  m_axi_wstrb,
    output logic               m_axi_wlast,
    output logic               m_axi_wvalid,
    input  logic               m_axi_wready,

    input  logic [IDWIDTH-1:0] m_axi_bid,
    input  logic [1:0]         m_axi_bresp,
    input  logic               m_axi_bvalid,
    output logic               m_axi_bready,

    output logic [AWIDTH-1:0]  m_axi_araddr,
    output logic [IDWIDTH-1:0] m_axi_arid,
    output logic [7:0]         m_axi_arlen,
    output logic [2:0]         m_axi_arsize,
    output logic [1:0]         m_axi_arburst,
    output logic               m_axi_arvalid,
    input  logic               m_axi_arready,

    input  logic [IDWIDTH-1:0] m_axi_rid,
    input  logic [DWIDTH-1:0]  m_axi_rdata,
    input  logic [1:0]         m_axi_rresp,
    input  logic               m_axi_rlast,
    input  logic               m_axi_rvalid,
    output logic               m_axi_rready
);

    localparam int SIZE_MAX = $clog2(DBYTES);

    typedef enum logic [2:0] {
        IDLE, WRITE, WAIT_B, RADDR, RDATA, DONE
    } state_t;

    state_t state, state_n;

    logic               q_write;
    logic [AWIDTH-1:0]  q_addr;
    logic [IDWIDTH-1:0] q_id;
    logic [7:0]         q_len;
    logic [2:0]         q_size;
    logic [1:0]         q_burst;
    logic [7:0]         beat;
    logic               aw_done;
    logic               w_done;
    logic               r_over;
    logic [1:0]         status;
    logic               err;
    logic               cmd_bad;
    logic               size_bad;

    assign size_bad = cmd_size > 3'(SIZE_MAX);

`ifdef AXI4_BURST_CHECK_EN
    logic [16:0]       incr_end;
    logic [AWIDTH-1:0] size_mask;
    logic              incr_cross;
    logic              wrap_bad;

    always_comb begin
        incr_end   = {5'd0, cmd_addr[11:0]} + ({8'd0, ({1'b0, cmd_len} + 9'd1)} << cmd_size);
        incr_cross = incr_end > 17'd4096;
        size_mask  = ~({AWIDTH{1'b1}} << cmd_size);
        wrap_bad   = !(cmd_len == 8'd1 || cmd_len == 8'd3 || cmd_len == 8'd7 || cmd_len == 8'd15)
                     || (|(cmd_addr & size_mask));
        cmd_bad    = size_bad
                     || (cmd_burst == 2'b01 && incr_cross)
                     || (cmd_burst == 2'b10 && wrap_bad)
                     || (cmd_burst == 2'b11);
    end
`else
    assign cmd_bad = size_bad;
`endif

    assign m_axi_awaddr  = q_addr;
    assign m_axi_awid    = q_id;
    assign m_axi_awlen   = q_len;
    assign m_axi_awsize  = q_size;
    assign m_axi_awburst = q_burst;
    assign m_axi_araddr  = q_addr;
    assign m_axi_arid    = q_id;
    assign m_axi_arlen   = q_len;
    assign m_axi_arsize  = q_size;
    assign m_axi_arburst = q_burst;

    assign m_axi_wdata = wr_data;
    assign m_axi_wstrb = wr_strb;
    assign rd_data     = m_axi_rdata;
    assign rd_last     = m_axi_rlast;
    assign done_write  = q_write;

    always_ff @(posedge clock_axi) begin
        if (!reset_axi_n) state <= IDLE;
        else              state <= state_n;
    end

    always_comb begin
        state_n       = state;
        cmd_ready     = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        wr_ready      = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_rready  = 1'b0;
        rd_valid      = 1'b0;
        done          = 1'b0;
        done_resp     = 2'b00;
        case (state)
            IDLE: begin
                cmd_ready = reset_axi_n;
                if (cmd_valid && reset_axi_n)
                    state_n = cmd_bad ? DONE : (cmd_write ? WRITE : RADDR);
            end
            WRITE: begin
                m_axi_awvalid = !aw_done;
                m_axi_wvalid  = wr_valid && !w_done;
                wr_ready      = m_axi_wready && !w_done;
                m_axi_wlast   = !w_done && (beat == q_len);
                // AW and W finish in either order; leave once both are complete
                if ((aw_done || m_axi_awready) &&
                    (w_done || (m_axi_wvalid && m_axi_wready && m_axi_wlast)))
                    state_n = WAIT_B;
            end
            WAIT_B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) state_n = DONE;
            end
            RADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_n = RDATA;
            end
            RDATA: begin
                m_axi_rready = rd_ready;
                rd_valid     = m_axi_rvalid;
                if (m_axi_rvalid && rd_ready && m_axi_rlast) state_n = DONE;
            end
            DONE: begin
                done      = 1'b1;
                done_resp = err ? 2'b10 : status;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock_axi) begin
        if (!reset_axi_n) begin
            q_write <= 1'b0;
            q_addr  <= '0;
            q_id    <= '0;
            q_len   <= '0;
            q_size  <= '0;
            q_burst <= '0;
            beat    <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            r_over  <= 1'b0;
            status  <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    q_write <= cmd_write;
                    q_addr  <= cmd_addr;
                    q_id    <= cmd_id;
                    q_len   <= cmd_len;
                    q_size  <= cmd_size;
                    q_burst <= cmd_burst;
                    beat    <= '0;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    r_over  <= 1'b0;
                    status  <= '0;
                    err     <= cmd_bad;
                end
                WRITE: begin
                    if (m_axi_awvalid && m_axi_awready) aw_done <= 1'b1;
                    if (m_axi_wvalid && m_axi_wready) begin
                        if (beat == q_len) w_done <= 1'b1;
                        else               beat   <= beat + 8'd1;
                    end
                end
                WAIT_B: if (m_axi_bvalid) begin
                    status <= m_axi_bresp;
                    if (m_axi_bid != q_id) err <= 1'b1;
                end
                RDATA: if (m_axi_rvalid && m_axi_rready) begin
                    if (m_axi_rresp > status) status <= m_axi_rresp;
                    if (m_axi_rid != q_id) err <= 1'b1;
                    // beats beyond len are drained until rlast but flagged
                    if (m_axi_rlast) begin
                        if (r_over || beat != q_len) err <= 1'b1;
                    end else if (r_over || beat == q_len) begin
                        err    <= 1'b1;
                        r_over <= 1'b1;
                    end else begin
                        beat <= beat + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
